// File: rtl/controle_busca_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// default geometry and the halt-word constant.
package controle_busca_pkg;

  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 32;

  // All-zero instruction word treated as a halt when halt detection is built in
  localparam logic [DW_DEF-1:0] HALT_WORD = '0;

  typedef enum logic {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

endpackage

// File: rtl/controle_busca.sv
// Instruction fetch controller: drives the external ROM address, registers
// the fetched word for decode with a valid/ready handshake, and handles
// redirects (desvio). Optional macro HALT_ON_ZERO_EN enables halting on an
// all-zero instruction word; reinicia then restarts fetch at address 0.
module controle_busca
  import controle_busca_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] endereco,
  input  logic [DW-1:0] instr_rom,
  input  logic          desvio,
  input  logic [AW-1:0] alvo,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          valido,
  input  logic          pronto,
  output logic          parado,
  input  logic          reinicia
);

`ifdef HALT_ON_ZERO_EN
  localparam logic [DW-1:0] HALT = DW'(HALT_WORD);
`endif

  estado_t       state, state_n;
  logic [AW-1:0] fetch_pc, fetch_n;
  logic [DW-1:0] instr_q, instr_n;
  logic [AW-1:0] pc_q, pc_n;
  logic          valido_q, valido_n;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BUSCA;
      fetch_pc <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      valido_q <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_n;
      instr_q  <= instr_n;
      pc_q     <= pc_n;
      valido_q <= valido_n;
    end
  end

  // Next-state logic: redirect beats load, load happens when the output slot
  // is empty or being consumed, otherwise everything holds (stall)
  always_comb begin
    state_n  = state;
    fetch_n  = fetch_pc;
    instr_n  = instr_q;
    pc_n     = pc_q;
    valido_n = valido_q;
    unique case (state)
      BUSCA: begin
        if (desvio) begin
          // Any coincident transfer has completed; the held word is dropped
          fetch_n  = alvo;
          valido_n = 1'b0;
        end else if (!valido_q || pronto) begin
`ifdef HALT_ON_ZERO_EN
          if (instr_rom == HALT) begin
            valido_n = 1'b0;
            state_n  = PARADO;
          end else
`endif
          begin
            instr_n  = instr_rom;
            pc_n     = fetch_pc;
            valido_n = 1'b1;
            fetch_n  = fetch_pc + AW'(1);
          end
        end
      end
      PARADO: begin
        if (reinicia) begin
          fetch_n  = '0;
          valido_n = 1'b0;
          state_n  = BUSCA;
        end
      end
      default: state_n = BUSCA;
    endcase
  end

  assign endereco = fetch_pc;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign valido   = valido_q;
  assign parado   = (state == PARADO);

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: table of directed vectors plus
// hand-written reset sequences. Build with +define+HALT_ON_ZERO_EN to
// exercise the halt path.
module tb_controle_busca;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] endereco;
  logic [DW-1:0] instr_rom;
  logic          desvio;
  logic [AW-1:0] alvo;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;
  logic          valido;
  logic          pronto;
  logic          parado;
  logic          reinicia;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM model: word 0 fixed, word 13 zero, others distinct nonzero
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    if (a == 4'd0)  return 32'h0090_3103;
    if (a == 4'd13) return 32'h0000_0000;
    return 32'hA500_0000 | (32'(a) << 8) | 32'(a);
  endfunction

  assign instr_rom = rom(endereco);

  controle_busca #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .endereco (endereco),
    .instr_rom(instr_rom),
    .desvio   (desvio),
    .alvo     (alvo),
    .instr    (instr),
    .pc       (pc),
    .valido   (valido),
    .pronto   (pronto),
    .parado   (parado),
    .reinicia (reinicia)
  );

  typedef struct {
    logic          desvio;
    logic [AW-1:0] alvo;
    logic          pronto;
    logic          reinicia;
    logic          e_valido;
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_end;
    logic          e_parado;
    logic          chk_data;
  } vec_t;

  vec_t tbl[40];
  int   n = 0;

  task automatic add(input logic d, input logic [AW-1:0] a, input logic p,
                     input logic r, input logic ev, input logic [AW-1:0] epc,
                     input logic [AW-1:0] eend, input logic epar, input logic cd);
    tbl[n].desvio   = d;
    tbl[n].alvo     = a;
    tbl[n].pronto   = p;
    tbl[n].reinicia = r;
    tbl[n].e_valido = ev;
    tbl[n].e_pc     = epc;
    tbl[n].e_instr  = rom(epc);
    tbl[n].e_end    = eend;
    tbl[n].e_parado = epar;
    tbl[n].chk_data = cd;
    n++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " valido"}, 64'(valido), 64'(v.e_valido));
    check({tag, " endereco"}, 64'(endereco), 64'(v.e_end));
    check({tag, " parado"}, 64'(parado), 64'(v.e_parado));
    if (v.chk_data) begin
      check({tag, " pc"}, 64'(pc), 64'(v.e_pc));
      check({tag, " instr"}, 64'(instr), 64'(v.e_instr));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    desvio = 1'b0; alvo = '0; pronto = 1'b1; reinicia = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    check("reset valido", 64'(valido), 64'd0);
    check("reset endereco", 64'(endereco), 64'd0);
    check("reset pc", 64'(pc), 64'd0);
    check("reset instr", 64'(instr), 64'd0);
    check("reset parado", 64'(parado), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // d  alvo  p  r   ev pc  end par chk
    add(0, 0,  1, 0,  1, 0,  1,  0, 1);   // first fetch, word 0
    add(0, 0,  1, 0,  1, 1,  2,  0, 1);
    add(0, 0,  1, 0,  1, 2,  3,  0, 1);
    add(0, 0,  0, 0,  1, 2,  3,  0, 1);   // 3-cycle stall at pc=2
    add(0, 0,  0, 0,  1, 2,  3,  0, 1);
    add(0, 0,  0, 0,  1, 2,  3,  0, 1);
    add(0, 0,  1, 0,  1, 3,  4,  0, 1);
    add(0, 0,  1, 0,  1, 4,  5,  0, 1);
    add(0, 0,  1, 0,  1, 5,  6,  0, 1);
    add(0, 0,  1, 0,  1, 6,  7,  0, 1);
    add(1, 8,  1, 0,  0, 0,  8,  0, 0);   // redirect while pc=6 valid
    add(0, 0,  1, 0,  1, 8,  9,  0, 1);
    add(1, 3,  0, 0,  0, 0,  3,  0, 0);   // redirect beats stall
    add(0, 0,  0, 0,  1, 3,  4,  0, 1);   // empty slot loads despite pronto=0
    add(0, 0,  1, 1,  1, 4,  5,  0, 1);   // reinicia ignored while fetching
    add(1, 12, 1, 0,  0, 0,  12, 0, 0);
    add(0, 0,  1, 0,  1, 12, 13, 0, 1);
`ifdef HALT_ON_ZERO_EN
    add(0, 0,  1, 0,  0, 0,  13, 1, 0);   // zero word at 13 halts
    add(1, 5,  1, 0,  0, 0,  13, 1, 0);   // desvio ignored when halted
    add(0, 0,  1, 0,  0, 0,  13, 1, 0);
    add(0, 0,  1, 1,  0, 0,  0,  0, 0);   // restart
    add(0, 0,  1, 0,  1, 0,  1,  0, 1);   // word 0 reissued
    add(0, 0,  1, 0,  1, 1,  2,  0, 1);
`else
    add(0, 0,  1, 0,  1, 13, 14, 0, 1);   // zero word issued normally
    add(0, 0,  1, 0,  1, 14, 15, 0, 1);
    add(0, 0,  1, 0,  1, 15, 0,  0, 1);
    add(0, 0,  1, 0,  1, 0,  1,  0, 1);   // wrap 15 -> 0
    add(0, 0,  1, 1,  1, 1,  2,  0, 1);
`endif

    for (int i = 0; i < n; i++) begin
      desvio   = tbl[i].desvio;
      alvo     = tbl[i].alvo;
      pronto   = tbl[i].pronto;
      reinicia = tbl[i].reinicia;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset in the middle of a stall
    idle_inputs();
    pronto = 1'b0;
    @(posedge clk); #1;
    check("stall before reset valido", 64'(valido), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async rst valido", 64'(valido), 64'd0);
    check("async rst pc", 64'(pc), 64'd0);
    check("async rst instr", 64'(instr), 64'd0);
    check("async rst endereco", 64'(endereco), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    pronto = 1'b1;
    @(posedge clk); #1;
    check("post rst valido", 64'(valido), 64'd1);
    check("post rst pc", 64'(pc), 64'd0);
    check("post rst instr", 64'(instr), 64'(rom(4'd0)));
    @(posedge clk); #1;
    check("post rst pc1", 64'(pc), 64'd1);

`ifdef HALT_ON_ZERO_EN
    // Straight run into the halt, then reset while halted
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    check("run last pc", 64'(pc), 64'd12);
    @(posedge clk); #1;
    check("run parado", 64'(parado), 64'd1);
    check("run endereco", 64'(endereco), 64'd13);
    #2;
    reset = 1'b1;
    #1;
    check("halt rst parado", 64'(parado), 64'd0);
    check("halt rst endereco", 64'(endereco), 64'd0);
    check("halt rst pc", 64'(pc), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
`else
    // Stall at the wrap boundary keeps endereco at 0 after pc=15
    idle_inputs();
    alvo = 4'd15; desvio = 1'b1;
    @(posedge clk); #1;
    desvio = 1'b0;
    @(posedge clk); #1;
    check("wrap pc15", 64'(pc), 64'd15);
    check("wrap end0", 64'(endereco), 64'd0);
    pronto = 1'b0;
    @(posedge clk); #1;
    check("wrap stall pc", 64'(pc), 64'd15);
    check("wrap stall end", 64'(endereco), 64'd0);
    check("parado stays 0", 64'(parado), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_busca.md
CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 SHALL have parameter AW, default 4, meaning instruction-ROM word-address width (16 words).
REQ-002 SHALL have parameter DW, default 32, meaning instruction width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port endereco  out  AW  fetch address to the instruction ROM, equal to internal fetch PC.
REQ-006 SHALL have port instr_rom  in  DW  ROM read data, combinational from endereco in the same cycle.
REQ-007 SHALL have port desvio  in  1  branch/jump redirect request, one-cycle pulse.
REQ-008 SHALL have port alvo  in  AW  redirect target word address, sampled when desvio=1.
REQ-009 SHALL have port instr  out  DW  registered instruction to decode.
REQ-010 SHALL have port pc  out  AW  registered address of instr.
REQ-011 SHALL have port valido  out  1  instr/pc hold a valid instruction.
REQ-012 SHALL have port pronto  in  1  decode accepts; transfer when valido&&pronto.
REQ-013 SHALL have port parado  out  1  fetch halted.
REQ-014 SHALL have port reinicia  in  1  leave halt, restart fetch at address 0.

Function
REQ-015 SHALL implement states BUSCA and PARADO; parado=1 exactly in PARADO.
REQ-016 In BUSCA with (!valido || pronto) and desvio=0, SHALL on the clock edge load instr<=instr_rom, pc<=endereco, valido<=1, fetch PC<=fetch PC+1.
REQ-017 Fetch PC increment SHALL wrap modulo 2^AW (15 -> 0 for AW=4), with no flag.
REQ-018 With valido=1 and pronto=0 (stall), instr, pc, valido and fetch PC SHALL hold unchanged.
REQ-019 desvio=1 in BUSCA SHALL take priority over fetch and stall: next edge fetch PC<=alvo, valido<=0 (held instruction flushed); the instruction at alvo SHALL appear with valido=1 one edge later.
REQ-020 desvio coincident with valido&&pronto SHALL count the current transfer as completed, then flush as REQ-019.
REQ-021 desvio and reinicia SHALL be ignored in PARADO, except as REQ-023.
REQ-022 Throughput SHALL be one instruction per cycle when pronto=1 continuously; latency endereco-to-instr one edge.
REQ-023 reinicia=1 in PARADO SHALL set fetch PC<=0, valido<=0, state<=BUSCA; reinicia in BUSCA SHALL be ignored.
REQ-024 Out-of-range behaviour SHALL be absent: every AW-bit address is valid.

Reset
REQ-025 Asserting reset SHALL immediately force state=BUSCA, fetch PC=0 (endereco=0), instr=0, pc=0, valido=0, parado=0, including mid-stall or mid-halt.
REQ-026 First valido=1 SHALL occur on the first rising edge after reset deasserts, carrying ROM word 0 with pc=0.

Configuration
REQ-027 Macro HALT_ON_ZERO_EN SHALL gate zero-word halt detection.
REQ-028 With HALT_ON_ZERO_EN defined, a load slot (REQ-016) seeing instr_rom==0 SHALL not issue it: valido<=0, fetch PC held at that address, state<=PARADO.
REQ-029 Without HALT_ON_ZERO_EN, zero words SHALL be issued like any instruction, PARADO unreachable, parado constant 0, reinicia ignored.

Structure
REQ-030 Package controle_busca_pkg SHALL hold the state enum, default AW/DW and the halt word constant (all-zero DW).
REQ-031 No sub-module SHALL be used; the ROM stays external, connected via endereco/instr_rom.

Verification
REQ-032 Reset release, pronto=1, ROM[0]=0x00903103 -> edge 1: valido=1, instr=0x00903103, pc=0; edge 2: pc=1.
REQ-033 pronto held 0 for 3 cycles at pc=2 -> instr, pc=2, valido stable; endereco stays 3; on pronto=1 next pc=3.
REQ-034 desvio=1, alvo=8 while pc=6 valid -> next edge valido=0; following edge pc=8, instr=ROM[8].
REQ-035 HALT_ON_ZERO_EN, ROM[13]=0, straight run from 0 -> last issued pc=12, then parado=1, valido=0, endereco=13; reinicia -> pc=0 reissued two edges later.
REQ-036 No macro, ROM all nonzero, pronto=1 -> pc sequence 14, 15, 0, 1 (wrap).
REQ-037 reset asserted mid-stall with valido=1 -> valido, pc, instr, endereco zero asynchronously, before next edge.
